// File: rtl/frame_mem_pkg.sv
// Shared types for the frame memory arbiter: read-tag layout, owner encoding
// and default bus widths.
package frame_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_VP  = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_VGA};

  function automatic tag_t make_tag(input logic valid, input owner_t owner);
    tag_t t;
    t.valid = valid;
    t.owner = owner;
    return t;
  endfunction

endpackage

// File: rtl/frame_mem_arbiter_rd_tag_pipe.sv
// Shift register of read tags whose depth matches issue register plus RAM read
// latency, so the output stage lines up with mem_rdata.
module rd_tag_pipe
  import frame_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage_reg [DEPTH];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= TAG_IDLE;
      end
    end else begin
      stage_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/frame_mem_arbiter.sv
// Single-port frame RAM arbiter: VGA has fixed priority, the vector processor is
// protected by a starvation counter, and read data is routed back by tag.
module frame_mem_arbiter
  import frame_mem_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              vga_urgent,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              vp_req,
  input  logic              vp_we,
  input  logic [ADDR_W-1:0] vp_addr,
  input  logic [DATA_W-1:0] vp_wdata,
  output logic              vp_gnt,
  output logic              vp_rvalid,
  output logic [DATA_W-1:0] vp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
  logic              force_vp;
  logic              vp_win, vga_win;
  logic              mem_en_reg, mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;
  tag_t              tag_push, tag_out;

  // Grants are masked while reset is held so every output reads 0 in reset.
  always_comb begin
    force_vp = (starve_cnt_reg >= CNT_MAX) && !vga_urgent;
    vp_win   = rst && vp_req && (!vga_req || force_vp);
    vga_win  = rst && vga_req && !vp_win;
  end

  always_comb begin
    starve_cnt_next = '0;
    if (vp_req && !vp_win) begin
      if (starve_cnt_reg >= CNT_MAX) begin
        starve_cnt_next = CNT_MAX;
      end else begin
        starve_cnt_next = starve_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_reg <= '0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      mem_en_reg     <= vp_win || vga_win;
      mem_we_reg     <= vp_win && vp_we;
      if (vp_win) begin
        mem_addr_reg <= vp_addr;
      end else if (vga_win) begin
        mem_addr_reg <= vga_addr;
      end
      if (vp_win && vp_we) begin
        mem_wdata_reg <= vp_wdata;
      end
    end
  end

  // Writes push an empty tag so the pipe keeps advancing one slot per cycle.
  always_comb begin
    tag_push = TAG_IDLE;
    if (vp_win && !vp_we) begin
      tag_push = make_tag(1'b1, OWN_VP);
    end else if (vga_win) begin
      tag_push = make_tag(1'b1, OWN_VGA);
    end
  end

  rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_rd_tag_pipe (
    .clk    (clk),
    .clr_n  (rst),
    .tag_in (tag_push),
    .tag_out(tag_out)
  );

  always_comb begin
    vga_rvalid = tag_out.valid && (tag_out.owner == OWN_VGA);
    vp_rvalid  = tag_out.valid && (tag_out.owner == OWN_VP);
    vga_rdata  = vga_rvalid ? mem_rdata : '0;
    vp_rdata   = vp_rvalid ? mem_rdata : '0;
  end

  assign vga_gnt   = vga_win;
  assign vp_gnt    = vp_win;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Bench for frame_mem_arbiter: two instances (read latency 1 and 3) share the
// stimulus and are checked against a transaction-level model every cycle.
module tb_frame_mem_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int LIM  = 8;
  localparam int LATA = 1;
  localparam int LATB = 3;

  typedef struct packed {
    logic          vga_gnt;
    logic          vga_rvalid;
    logic [DW-1:0] vga_rdata;
    logic          vp_gnt;
    logic          vp_rvalid;
    logic [DW-1:0] vp_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_en;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
  } outs_t;

  typedef struct {
    int            due;
    logic          owner;
    logic [DW-1:0] data;
  } resp_t;

  typedef struct {
    logic vq;
    logic pq;
    logic urg;
    logic e_vga;
    logic e_vp;
  } gvec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          vga_req = 1'b0, vga_urgent = 1'b0, vp_req = 1'b0, vp_we = 1'b0;
  logic [AW-1:0] vga_addr = '0, vp_addr = '0;
  logic [DW-1:0] vp_wdata = '0;

  logic          la_vga_gnt, la_vga_rvalid, la_vp_gnt, la_vp_rvalid, la_mem_en, la_mem_we;
  logic [DW-1:0] la_vga_rdata, la_vp_rdata, la_mem_wdata, la_mem_rdata;
  logic [AW-1:0] la_mem_addr;
  logic          lb_vga_gnt, lb_vga_rvalid, lb_vp_gnt, lb_vp_rvalid, lb_mem_en, lb_mem_we;
  logic [DW-1:0] lb_vga_rdata, lb_vp_rdata, lb_mem_wdata, lb_mem_rdata;
  logic [AW-1:0] lb_mem_addr;

  frame_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LATA), .STARVE_LIMIT(LIM)) u_lat1 (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_urgent(vga_urgent),
    .vga_gnt(la_vga_gnt), .vga_rvalid(la_vga_rvalid), .vga_rdata(la_vga_rdata),
    .vp_req(vp_req), .vp_we(vp_we), .vp_addr(vp_addr), .vp_wdata(vp_wdata),
    .vp_gnt(la_vp_gnt), .vp_rvalid(la_vp_rvalid), .vp_rdata(la_vp_rdata),
    .mem_addr(la_mem_addr), .mem_en(la_mem_en), .mem_we(la_mem_we),
    .mem_wdata(la_mem_wdata), .mem_rdata(la_mem_rdata)
  );

  frame_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LATB), .STARVE_LIMIT(LIM)) u_lat3 (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_urgent(vga_urgent),
    .vga_gnt(lb_vga_gnt), .vga_rvalid(lb_vga_rvalid), .vga_rdata(lb_vga_rdata),
    .vp_req(vp_req), .vp_we(vp_we), .vp_addr(vp_addr), .vp_wdata(vp_wdata),
    .vp_gnt(lb_vp_gnt), .vp_rvalid(lb_vp_rvalid), .vp_rdata(lb_vp_rdata),
    .mem_addr(lb_mem_addr), .mem_en(lb_mem_en), .mem_we(lb_mem_we),
    .mem_wdata(lb_mem_wdata), .mem_rdata(lb_mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 16'h0100) return 32'hDEAD_BEEF;
    return {~a, a} ^ 32'h5A5A_0000;
  endfunction

  // Frame RAM models, one per instance, with the instance's read latency.
  logic [DW-1:0] ram_a [65536];
  bit            wr_a  [65536];
  logic [DW-1:0] rd_a_q;
  always @(posedge clk) begin
    if (la_mem_en && la_mem_we) begin
      ram_a[la_mem_addr] <= la_mem_wdata;
      wr_a[la_mem_addr]  <= 1'b1;
    end
    rd_a_q <= wr_a[la_mem_addr] ? ram_a[la_mem_addr] : init_word(la_mem_addr);
  end
  assign la_mem_rdata = rd_a_q;

  logic [DW-1:0] ram_b [65536];
  bit            wr_b  [65536];
  logic [DW-1:0] rd_b_q [LATB];
  always @(posedge clk) begin
    if (lb_mem_en && lb_mem_we) begin
      ram_b[lb_mem_addr] <= lb_mem_wdata;
      wr_b[lb_mem_addr]  <= 1'b1;
    end
    rd_b_q[0] <= wr_b[lb_mem_addr] ? ram_b[lb_mem_addr] : init_word(lb_mem_addr);
    for (int i = 1; i < LATB; i++) rd_b_q[i] <= rd_b_q[i-1];
  end
  assign lb_mem_rdata = rd_b_q[LATB-1];

  outs_t outs_a, outs_b;
  assign outs_a = {la_vga_gnt, la_vga_rvalid, la_vga_rdata, la_vp_gnt, la_vp_rvalid, la_vp_rdata,
                   la_mem_addr, la_mem_en, la_mem_we, la_mem_wdata};
  assign outs_b = {lb_vga_gnt, lb_vga_rvalid, lb_vga_rdata, lb_vp_gnt, lb_vp_rvalid, lb_vp_rdata,
                   lb_mem_addr, lb_mem_en, lb_mem_we, lb_mem_wdata};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level model state: memory image, starvation count, expected
  // issue-register contents and per-instance response schedules.
  logic [DW-1:0] mdl_mem [65536];
  bit            mdl_wr  [65536];
  int            starve = 0;
  logic          exp_en = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          last_g_vga = 1'b0, last_g_vp = 1'b0;
  resp_t         qa [$];
  resp_t         qb [$];
  gvec_t         gtab [7];

  function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
    return mdl_wr[a] ? mdl_mem[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    outs_t         ob;
    resp_t         fr;
    logic          has;
    logic          force_vp, g_vp, g_vga;
    logic [DW-1:0] d;
    for (int k = 0; k < 2; k++) begin
      ob = (k == 0) ? outs_a : outs_b;
      if (!rst) begin
        check($sformatf("reset_outputs[%0d]", k), 128'(ob), 128'(0));
      end else begin
        check($sformatf("mem_en[%0d]", k), 128'(ob.mem_en), 128'(exp_en));
        check($sformatf("mem_we[%0d]", k), 128'(ob.mem_we), 128'(exp_we));
        check($sformatf("mem_addr[%0d]", k), 128'(ob.mem_addr), 128'(exp_addr));
        check($sformatf("mem_wdata[%0d]", k), 128'(ob.mem_wdata), 128'(exp_wdata));
        has = 1'b0;
        fr.owner = 1'b0;
        fr.data = '0;
        fr.due = 0;
        if (k == 0 && qa.size() > 0 && qa[0].due == cyc) begin
          fr = qa.pop_front();
          has = 1'b1;
        end
        if (k == 1 && qb.size() > 0 && qb[0].due == cyc) begin
          fr = qb.pop_front();
          has = 1'b1;
        end
        check($sformatf("vga_rvalid[%0d]", k), 128'(ob.vga_rvalid), 128'(has && !fr.owner));
        check($sformatf("vp_rvalid[%0d]", k), 128'(ob.vp_rvalid), 128'(has && fr.owner));
        if (has && !fr.owner) check($sformatf("vga_rdata[%0d]", k), 128'(ob.vga_rdata), 128'(fr.data));
        if (has && fr.owner) check($sformatf("vp_rdata[%0d]", k), 128'(ob.vp_rdata), 128'(fr.data));
      end
    end
    if (!rst) begin
      qa.delete();
      qb.delete();
      starve = 0;
      exp_en = 1'b0;
      exp_we = 1'b0;
      exp_addr = '0;
      exp_wdata = '0;
      last_g_vga = 1'b0;
      last_g_vp = 1'b0;
    end else begin
      force_vp = (starve >= LIM) && !vga_urgent;
      g_vp  = vp_req && (!vga_req || force_vp);
      g_vga = vga_req && !g_vp;
      check("vga_gnt[0]", 128'(la_vga_gnt), 128'(g_vga));
      check("vp_gnt[0]", 128'(la_vp_gnt), 128'(g_vp));
      check("vga_gnt[1]", 128'(lb_vga_gnt), 128'(g_vga));
      check("vp_gnt[1]", 128'(lb_vp_gnt), 128'(g_vp));
      if (g_vp || !vp_req) starve = 0;
      else if (starve < LIM) starve = starve + 1;
      exp_en = g_vp || g_vga;
      exp_we = g_vp && vp_we;
      if (g_vp) begin
        exp_addr = vp_addr;
        if (vp_we) begin
          exp_wdata = vp_wdata;
          mdl_mem[vp_addr] = vp_wdata;
          mdl_wr[vp_addr] = 1'b1;
        end else begin
          d = mdl_rd(vp_addr);
          qa.push_back('{cyc + 1 + LATA, 1'b1, d});
          qb.push_back('{cyc + 1 + LATB, 1'b1, d});
        end
      end else if (g_vga) begin
        exp_addr = vga_addr;
        d = mdl_rd(vga_addr);
        qa.push_back('{cyc + 1 + LATA, 1'b0, d});
        qb.push_back('{cyc + 1 + LATB, 1'b0, d});
      end
      last_g_vga = g_vga;
      last_g_vp = g_vp;
    end
  endtask

  task automatic cycle_io(input logic r, input logic vq, input logic [AW-1:0] va,
                          input logic pq, input logic pwe, input logic [AW-1:0] pa,
                          input logic [DW-1:0] pwd, input logic urg);
    @(posedge clk);
    #1;
    rst = r;
    vga_req = vq;
    vga_addr = va;
    vp_req = pq;
    vp_we = pwe;
    vp_addr = pa;
    vp_wdata = pwd;
    vga_urgent = urg;
    @(negedge clk);
    model_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_io(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int            pulses;
    logic [DW-1:0] got;
    logic          e_v;
    logic          vq_r, pq_r, pwe_r, urg_r, r_v;
    logic [AW-1:0] va_r, pa_r;
    logic [DW-1:0] pwd_r;

    gtab[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    gtab[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    gtab[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    gtab[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    gtab[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    gtab[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gtab[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with a pending VGA request: nothing may leak out.
    for (int i = 0; i < 3; i++) begin
      cycle_io(1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, 1'b0);
      check("reset_vga_gnt", 128'(la_vga_gnt), 128'(0));
    end
    // Read granted, then reset pulsed the next cycle: its response is dropped.
    cycle_io(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, 1'b0);
    check("midread_grant", 128'(la_vga_gnt), 128'(1));
    cycle_io(1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, '0, '0, 1'b0);
    check("midread_mem_en", 128'(la_mem_en), 128'(0));
    for (int i = 0; i < 6; i++) begin
      idle(1);
      check("midread_no_rvalid_l1", 128'(la_vga_rvalid), 128'(0));
      check("midread_no_rvalid_l3", 128'(lb_vga_rvalid), 128'(0));
    end

    // Grant truth table from a cleared starvation count.
    for (int i = 0; i < 7; i++) begin
      cycle_io(1'b1, gtab[i].vq, 16'(16'h0020 + i), gtab[i].pq, 1'b0, 16'(16'h0030 + i), '0, gtab[i].urg);
      check($sformatf("table%0d_vga_gnt", i), 128'(la_vga_gnt), 128'(gtab[i].e_vga));
      check($sformatf("table%0d_vp_gnt", i), 128'(la_vp_gnt), 128'(gtab[i].e_vp));
      idle(1);
    end
    idle(5);

    // Single VP read, then the same address from VGA.
    cycle_io(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'h0100, '0, 1'b0);
    check("single_vp_gnt", 128'(la_vp_gnt), 128'(1));
    idle(1);
    check("single_vp_early", 128'(la_vp_rvalid), 128'(0));
    idle(1);
    check("single_vp_rvalid", 128'(la_vp_rvalid), 128'(1));
    check("single_vp_rdata", 128'(la_vp_rdata), 128'(32'hDEAD_BEEF));
    check("single_vp_vga_quiet", 128'(la_vga_rvalid), 128'(0));
    idle(3);
    cycle_io(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, '0, '0, 1'b0);
    check("single_vga_gnt", 128'(la_vga_gnt), 128'(1));
    idle(2);
    check("single_vga_rvalid", 128'(la_vga_rvalid), 128'(1));
    check("single_vga_rdata", 128'(la_vga_rdata), 128'(32'hDEAD_BEEF));
    check("single_vga_vp_quiet", 128'(la_vp_rvalid), 128'(0));
    idle(4);

    // Write followed immediately by a read of the same word.
    pulses = 0;
    got = '0;
    cycle_io(1'b1, 1'b0, '0, 1'b1, 1'b1, 16'h0042, 32'h1234_5678, 1'b0);
    check("raw_write_gnt", 128'(la_vp_gnt), 128'(1));
    if (la_vp_rvalid) pulses++;
    cycle_io(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'h0042, '0, 1'b0);
    if (la_vp_rvalid) pulses++;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (la_vp_rvalid) begin
        pulses++;
        got = la_vp_rdata;
      end
    end
    check("raw_pulse_count", 128'(pulses), 128'(1));
    check("raw_read_data", 128'(got), 128'(32'h1234_5678));
    idle(2);

    // Continuous contention: VP wins every ninth cycle.
    for (int i = 0; i < 27; i++) begin
      cycle_io(1'b1, 1'b1, 16'h0100, 1'b1, 1'b0, 16'h0042, '0, 1'b0);
      check($sformatf("starve_vp_gnt%0d", i), 128'(la_vp_gnt), 128'((i % 9) == 8));
      check($sformatf("starve_vga_gnt%0d", i), 128'(la_vga_gnt), 128'((i % 9) != 8));
    end
    idle(6);

    // Urgent from cycle 5 to 14 holds off the forced grant until it drops.
    for (int i = 0; i < 18; i++) begin
      cycle_io(1'b1, 1'b1, 16'h0007, 1'b1, 1'b0, 16'h0009, '0, (i >= 5 && i < 15));
      check($sformatf("urgent_vp_gnt%0d", i), 128'(la_vp_gnt), 128'(i == 15));
    end
    idle(6);

    // Alternating owners through the latency-3 instance.
    for (int j = 0; j < 13; j++) begin
      if (j < 8) begin
        if ((j % 2) == 0) cycle_io(1'b1, 1'b1, 16'(16'h0200 + j), 1'b0, 1'b0, '0, '0, 1'b0);
        else              cycle_io(1'b1, 1'b0, '0, 1'b1, 1'b0, 16'(16'h0200 + j), '0, 1'b0);
      end else begin
        idle(1);
      end
      e_v = (j >= 4) && (j < 12);
      check($sformatf("inter_vga_rvalid%0d", j), 128'(lb_vga_rvalid), 128'(e_v && ((j % 2) == 0)));
      check($sformatf("inter_vp_rvalid%0d", j), 128'(lb_vp_rvalid), 128'(e_v && ((j % 2) == 1)));
      if (e_v && (j % 2) == 0)
        check($sformatf("inter_vga_rdata%0d", j), 128'(lb_vga_rdata), 128'(init_word(16'(16'h0200 + j - 4))));
      if (e_v && (j % 2) == 1)
        check($sformatf("inter_vp_rdata%0d", j), 128'(lb_vp_rdata), 128'(init_word(16'(16'h0200 + j - 4))));
    end
    idle(4);

    // Random traffic: requesters hold until accepted.
    vq_r = 1'b0; pq_r = 1'b0; pwe_r = 1'b0; urg_r = 1'b0;
    va_r = '0; pa_r = '0; pwd_r = '0;
    for (int n = 0; n < 1500; n++) begin
      if (vq_r && last_g_vga) vq_r = 1'b0;
      if (pq_r && last_g_vp) pq_r = 1'b0;
      if (!vq_r && $urandom_range(0, 9) < 7) begin
        vq_r = 1'b1;
        va_r = 16'($urandom_range(0, 31));
      end
      if (!pq_r && $urandom_range(0, 9) < 6) begin
        pq_r  = 1'b1;
        pwe_r = 1'($urandom_range(0, 1));
        pa_r  = 16'($urandom_range(0, 31));
        pwd_r = $urandom;
      end
      if ($urandom_range(0, 15) == 0) urg_r = !urg_r;
      r_v = (n != 700);
      cycle_io(r_v, vq_r, va_r, pq_r, pwe_r, pa_r, pwd_r, urg_r);
    end
    idle(8);
    check("drain_queue_l1", 128'(qa.size()), 128'(0));
    check("drain_queue_l3", 128'(qb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
